// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-side bus arbiter and system_bus address map.
package bus_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bus_state_t;

  // Read data returned to the owner when the watchdog fires.
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  // Address-map bases (byte address bits [7:0]) shared with system_bus.
  localparam logic [7:0] MEM_BASE   = 8'h00;
  localparam logic [7:0] TIMER_BASE = 8'h10;
  localparam logic [7:0] GPIO_BASE  = 8'h20;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select: on a tie the master that did not win last time wins.
module rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_any_req,
  output logic o_winner
);

  assign o_any_req = i_req0 | i_req1;
  assign o_winner  = (i_req0 & i_req1) ? ~i_last_grant : i_req1;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the system_bus CPU port, one transfer at a time.
// Optional watchdog enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_we,
  input  logic              m0_re,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_we,
  input  logic              m1_re,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic              bus_err,
  output bus_state_t        dbg_state
);

  bus_state_t  r_state;
  logic        r_owner;
  logic        r_last_grant;

  logic        w_m0_req, w_m1_req, w_any_req, w_winner;
  logic        w_busy, w_own_we, w_own_re, w_own_req, w_done, w_finish;
  logic [DATA_W-1:0] w_rdata;

  assign w_m0_req = m0_we | m0_re;
  assign w_m1_req = m1_we | m1_re;

  rr_arb2 u_rr_arb2 (
    .i_req0       (w_m0_req),
    .i_req1       (w_m1_req),
    .i_last_grant (r_last_grant),
    .o_any_req    (w_any_req),
    .o_winner     (w_winner)
  );

  assign w_busy    = (r_state == ST_BUSY);
  assign w_own_we  = r_owner ? m1_we : m0_we;
  assign w_own_re  = r_owner ? m1_re : m0_re;
  assign w_own_req = w_own_we | w_own_re;
  // Completion only counts while the owner still holds its request.
  assign w_done    = w_busy & w_own_req & bus_ready;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] r_timer;
  logic       w_timeout;

  assign w_timeout = w_busy & w_own_req & ~bus_ready & (r_timer == TO_LIMIT);
  assign w_finish  = w_done | w_timeout;
  assign w_rdata   = w_timeout ? DATA_W'(BUS_ERR_DATA) : bus_rdata;
  assign bus_err   = w_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= 8'd0;
    end else if (!w_busy || !w_own_req || w_finish) begin
      r_timer <= 8'd0;
    end else if (!bus_ready) begin
      r_timer <= r_timer + 8'd1;
    end
  end
`else
  assign w_finish = w_done;
  assign w_rdata  = bus_rdata;
  assign bus_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A dropped request aborts without a ready pulse.
          if (!w_own_req || w_finish) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_we    = w_busy & w_own_we;
  assign bus_re    = w_busy & w_own_re & ~w_own_we;
  assign bus_addr  = w_busy ? (r_owner ? m1_addr : m0_addr) : '0;
  assign bus_wdata = w_busy ? (r_owner ? m1_wdata : m0_wdata) : '0;

  assign m0_ready  = w_finish & ~r_owner;
  assign m1_ready  = w_finish & r_owner;
  assign m0_rdata  = m0_ready ? w_rdata : '0;
  assign m1_rdata  = m1_ready ? w_rdata : '0;

  assign dbg_state = r_state;

endmodule
